shift_frame_ctrl: RTL and testbench
===================================

# shift_frame_ctrl

Sequencing controller that drives an n-bit bidirectional shift register to capture serial frames of programmable length. It accepts a start command with a direction and length, enables the shift register for exactly `len` valid serial bits, then presents the captured word on a valid/ready output port. It sits between a serial front end (bit stream plus qualifier) and the parallel consumer logic.

## Interface
- `WIDTH`, default 8: shift register width, and the maximum frame length in bits (≥2).
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the length and bit-count fields.
- `clk`  in  1: single clock; all logic updates on posedge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: frame request, sampled only in IDLE.
- `dir`  in  1: direction, latched at accept.
  - 0 = shift left, new bit enters bit 0.
  - 1 = shift right, new bit enters bit WIDTH-1.
- `len`  in  CNT_W: number of bits to capture, latched at accept; legal range 1..WIDTH.
- `abort`  in  1: cancel the current frame.
- `ser_in`  in  1: serial data bit.
- `ser_valid`  in  1: `ser_in` qualifier.
- `frame_data`  out  WIDTH: raw shift register contents.
- `frame_valid`  out  1: captured frame available.
- `frame_ready`  in  1: consumer accepts the frame.
- `busy`  out  1: high in SHIFT or DONE.
- `len_err`  out  1: one-cycle pulse when `start` arrives with an illegal `len`.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `start`=1 with 1≤`len`≤WIDTH: latch `dir` and `len`, clear the register to 0, clear the bit count, go to SHIFT.
  - `start`=1 with `len`=0 or `len`>WIDTH: stay in IDLE, pulse `len_err` next cycle, register unchanged.
- **SHIFT**
  - Each cycle with `ser_valid`=1: shift `ser_in` in per the latched `dir` and increment the count.
  - When the count reaches `len`, the same edge moves to DONE.
  - `ser_valid`=0: hold register and count.
- **DONE**
  - `frame_valid`=1 and `frame_data` stable.
  - `frame_valid`&&`frame_ready`: go to IDLE.
  - `start` and `ser_valid` are ignored.
- **abort**
  - In SHIFT or DONE: next state IDLE, register cleared, count cleared, no `frame_valid`.
  - Takes priority over `ser_valid` and `frame_ready` in the same cycle.
  - Ignored in IDLE.
- **Bit placement**
  - `dir`=0: the frame occupies [len-1:0], first bit at [len-1].
  - `dir`=1: the frame occupies [WIDTH-1:WIDTH-len], first bit at [WIDTH-len].
  - Unused bits are 0.
- `busy` is 1 in SHIFT and DONE, 0 in IDLE.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, register 0, count 0, `frame_valid`=0, `busy`=0, `len_err`=0, `frame_data`=0. Reset applied mid-frame discards the frame.
- Start accepted at edge T: `busy`=1 from T+1; first bit sampled at edge T+1.
- With `ser_valid` held high, the last bit is captured at edge T+len and `frame_valid` rises after T+len.
- Handshake at edge H: `frame_valid` drops after H. A new `start` can be accepted at edge H+1 at the earliest.
- Minimum frame period is `len`+2 cycles.
- All outputs are registered or decoded only from state; no combinational path from inputs to outputs.
- `len_err` is high for exactly one cycle per illegal `start` edge.

## Structure
- Package `shift_ctrl_pkg`: state enum typedef (IDLE/SHIFT/DONE) and constants DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module `shift_core`: WIDTH-bit bidirectional shift register with synchronous clear, enable, direction and serial input, and synchronous active-low reset. The controller instantiates it and drives clear/enable/direction from the FSM and count.
- Controller contents: FSM, CNT_W counter, latched `dir` and `len`.

## Test plan
- Reset mid-SHIFT (3 of 8 bits captured) → next cycle IDLE, `frame_data`=0, `busy`=0, no `frame_valid`.
- `dir`=0, `len`=8, `ser_valid` constantly high, bits 1,0,1,1,0,0,1,0 → `frame_data`=8'hB2, `frame_valid` rises 9 cycles after accept.
- `dir`=1, `len`=4, bits 1,1,0,1 with `ser_valid` low for 2 cycles between bits 2 and 3 → `frame_data`=8'hB0, `frame_valid` rises 7 cycles after accept.
- `frame_ready` held low for 5 cycles in DONE while `start` and `ser_in` toggle → `frame_data` unchanged and `start` ignored. Ready then asserted → IDLE, and a new `start` one cycle later is accepted.
- `start` with `len`=0 and then with `len`=9 (WIDTH=8) → one `len_err` pulse each, state stays IDLE.
- `abort` asserted together with the last `ser_valid` bit → no `frame_valid`, IDLE next cycle, register 0.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types for the serial frame capture controller: FSM state encoding
// and shift direction codes.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_core.sv
// Bidirectional shift register with synchronous clear and shift enable.
// Clear has priority over a shift in the same cycle.
module shift_core
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (enable) begin
      if (dir == DIR_LEFT) begin
        data <= {data[WIDTH-2:0], ser_in};
      end else begin
        data <= {ser_in, data[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: accepts a start/dir/len command, enables the shift core
// for exactly len qualified bits, then holds the word on a valid/ready port.
module shift_frame_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic             len_err
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_q;
  logic             dir_q;
  logic             len_ok;
  logic             accept;
  logic             core_clear;
  logic             core_en;

  assign len_ok  = (len != '0) && (len <= MAX_LEN);
  assign accept  = (state == IDLE) && start && len_ok;
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks both a shift and a handshake in the same cycle.
  always_comb begin
    state_nxt  = state;
    core_clear = 1'b0;
    core_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          core_clear = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          core_clear = 1'b1;
          state_nxt  = IDLE;
        end else if (ser_valid) begin
          core_en = 1'b1;
          if (cnt_inc == len_q) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          core_clear = 1'b1;
          state_nxt  = IDLE;
        end else if (frame_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      len_q <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      if (core_clear) begin
        cnt <= '0;
      end else if (core_en) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        len_q <= len;
        dir_q <= dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_err <= 1'b0;
    end else begin
      len_err <= (state == IDLE) && start && !len_ok;
    end
  end

  shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (core_clear),
    .enable(core_en),
    .dir   (dir_q),
    .ser_in(ser_in),
    .data  (frame_data)
  );

  assign frame_valid = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed self-checking bench for shift_frame_ctrl with hand-computed
// expected frames and cycle positions.
module tb_shift_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [3:0] len;
  logic       abort;
  logic       ser_in;
  logic       ser_valid;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic       len_err;

  int total = 0;
  int bad   = 0;

  shift_frame_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dir        (dir),
    .len        (len),
    .abort      (abort),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy       (busy),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, and settle 1 time unit after it
  task automatic applyStimulus(input logic st, input logic d, input logic [3:0] l,
                               input logic ab, input logic si, input logic sv,
                               input logic rdy);
    start       = st;
    dir         = d;
    len         = l;
    abort       = ab;
    ser_in      = si;
    ser_valid   = sv;
    frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bits_a;
  logic [3:0] bits_b;

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_data", frame_data, 8'h00);
    checkOutput("rst_valid", frame_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_lenerr", len_err, 0);
    rst_n = 1'b1;

    // Reset in the middle of a frame
    applyStimulus(1, 0, 8, 0, 0, 0, 0);
    checkOutput("mid_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("mid_partial", frame_data, 8'h05);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    checkOutput("mid_rst_data", frame_data, 8'h00);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_valid", frame_valid, 0);

    // Left shift, len 8, bits 1,0,1,1,0,0,1,0 -> B2
    bits_a = 8'b1011_0010;
    applyStimulus(1, 0, 8, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(0, 0, 0, 0, bits_a[i], 1, 0);
      if (i == 1) checkOutput("b2_valid_early", frame_valid, 0);
    end
    checkOutput("b2_valid", frame_valid, 1);
    checkOutput("b2_data", frame_data, 8'hB2);

    // DONE holds while ready is low; start and serial input are ignored
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 1, 3, 0, ~i[0], 1, 0);
      checkOutput("hold_data", frame_data, 8'hB2);
      checkOutput("hold_valid", frame_valid, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("hs_valid", frame_valid, 0);
    checkOutput("hs_busy", busy, 0);

    // Right shift, len 4, bits 1,1,(gap 2),0,1 -> B0, start right after handshake
    bits_b = 4'b1101;
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    checkOutput("b0_accept", busy, 1);
    applyStimulus(0, 0, 0, 0, bits_b[3], 1, 0);
    applyStimulus(0, 0, 0, 0, bits_b[2], 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("b0_gap_hold", frame_data, 8'hC0);
    applyStimulus(0, 0, 0, 0, bits_b[1], 1, 0);
    checkOutput("b0_valid_early", frame_valid, 0);
    applyStimulus(0, 0, 0, 0, bits_b[0], 1, 0);
    checkOutput("b0_valid", frame_valid, 1);
    checkOutput("b0_data", frame_data, 8'hB0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("b0_hs_busy", busy, 0);

    // Illegal lengths
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("len0_err", len_err, 1);
    checkOutput("len0_busy", busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("len0_pulse", len_err, 0);
    applyStimulus(1, 0, 9, 0, 0, 0, 0);
    checkOutput("len9_err", len_err, 1);
    checkOutput("len9_busy", busy, 0);
    checkOutput("len9_data", frame_data, 8'hB0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("len9_pulse", len_err, 0);

    // Minimum length, right shift: single bit lands in bit 7
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("len1_valid", frame_valid, 1);
    checkOutput("len1_data", frame_data, 8'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Abort together with the last qualified bit
    applyStimulus(1, 0, 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 0);
    checkOutput("abort_valid", frame_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_data", frame_data, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("abort_after", frame_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
